// File: rtl/axi_llc_data_sram_arb.sv
// Round-robin arbiter sharing one data-SRAM port between NumReq LLC units, with a
// Latency-deep response sequencer. Define AXI_LLC_DATA_ARB_PRIO_EN to give requester 0 strict priority.
module axi_llc_data_sram_arb #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq-1:0]                 req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]  req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]    req_be_i,
  output logic [NumReq-1:0]                 rsp_valid_o,
  output logic                              rsp_we_o,
  output logic [DataWidth-1:0]              rsp_rdata_o,
  output logic                              sram_req_o,
  output logic                              sram_we_o,
  output logic [AddrWidth-1:0]              sram_addr_o,
  output logic [DataWidth-1:0]              sram_wdata_o,
  output logic [BeWidth-1:0]                sram_be_o,
  input  logic [DataWidth-1:0]              sram_rdata_i
);

  localparam int unsigned RrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [RrW-1:0]    rr_q, rr_d;
  logic [RrW-1:0]    gnt_idx, idx;
  logic [RrW-1:0]    rr_next;
  logic [NumReq-1:0] gnt;
  logic              xfer;

  // Search starts at the pointer and wraps; first valid index wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    xfer    = 1'b0;
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
    if (req_valid_i[0]) begin
      gnt[0] = 1'b1;
      xfer   = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = RrW'((32'(rr_q) + k) % NumReq);
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
      if (!xfer && (idx != '0) && req_valid_i[idx]) begin
`else
      if (!xfer && req_valid_i[idx]) begin
`endif
        xfer     = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  assign req_ready_o = gnt;
  assign rr_next     = RrW'((32'(gnt_idx) + 1) % NumReq);

  always_comb begin
    rr_d = rr_q;
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
    // Requester 0 bypasses the rotation, so it must not disturb the pointer.
    if (xfer && (gnt_idx != '0)) rr_d = rr_next;
`else
    if (xfer) rr_d = rr_next;
`endif
  end

  assign sram_req_o   = xfer;
  assign sram_we_o    = xfer & req_we_i[gnt_idx];
  assign sram_addr_o  = xfer ? req_addr_i[gnt_idx]  : '0;
  assign sram_wdata_o = xfer ? req_wdata_i[gnt_idx] : '0;
  assign sram_be_o    = xfer ? req_be_i[gnt_idx]    : '0;

  logic [Latency-1:0]             vld_pipe;
  logic [Latency-1:0]             we_pipe;
  logic [Latency-1:0][NumReq-1:0] id_pipe;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      vld_pipe <= '0;
      we_pipe  <= '0;
      id_pipe  <= '0;
    end else begin
      rr_q        <= rr_d;
      vld_pipe[0] <= xfer;
      we_pipe[0]  <= sram_we_o;
      id_pipe[0]  <= gnt;
      for (int i = 1; i < Latency; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        we_pipe[i]  <= we_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign rsp_valid_o = vld_pipe[Latency-1] ? id_pipe[Latency-1] : '0;
  assign rsp_we_o    = we_pipe[Latency-1];
  assign rsp_rdata_o = (vld_pipe[Latency-1] && !we_pipe[Latency-1]) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_axi_llc_data_sram_arb.sv
// Bench for axi_llc_data_sram_arb: SRAM model plus a transaction-level reference of
// grants and responses; honours AXI_LLC_DATA_ARB_PRIO_EN.
module tb_axi_llc_data_sram_arb;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int DW  = 32;
  localparam int NW  = 64;
  localparam int AW  = 6;
  localparam int BEW = 4;

  logic                    clk, rst_n;
  logic [NR-1:0]           req_valid, req_ready, req_we, rsp_valid;
  logic [NR-1:0][AW-1:0]   req_addr;
  logic [NR-1:0][DW-1:0]   req_wdata;
  logic [NR-1:0][BEW-1:0]  req_be;
  logic                    rsp_we, sram_req, sram_we;
  logic [DW-1:0]           rsp_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0]           sram_addr;
  logic [BEW-1:0]          sram_be;

  axi_llc_data_sram_arb #(
    .NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: byte-masked writes, reads return LAT cycles after the request.
  logic               clr;
  logic [DW-1:0]      mem [NW];
  logic [LAT-1:0][DW-1:0] rd_pipe;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NW; i++) mem[i] <= '0;
    end else if (sram_req && sram_we) begin
      for (int b = 0; b < BEW; b++)
        if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= (sram_req && !sram_we) ? mem[sram_addr] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[LAT-1];

  // Reference model: pointer, queue of in-flight responses, memory contents.
  typedef struct { bit v; bit [NR-1:0] id; bit we; bit [DW-1:0] d; } rsp_t;
  rsp_t          pipe_m[$];
  int            rr_m;
  bit [DW-1:0]   ref_mem [NW];
  int            eg;
  rsp_t          er;
  int            tests, fails;

  task automatic eval_cycle();
    @(negedge clk);
    eg = -1;
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
    if (req_valid[0]) eg = 0;
    else
      for (int k = 0; k < NR; k++) begin
        int i = (rr_m + k) % NR;
        if (eg < 0 && i != 0 && req_valid[i]) eg = i;
      end
`else
    for (int k = 0; k < NR; k++) begin
      int i = (rr_m + k) % NR;
      if (eg < 0 && req_valid[i]) eg = i;
    end
`endif
    er = pipe_m[0];
  endtask

  task automatic advance();
    rsp_t n;
    @(posedge clk);
    n.v = (eg >= 0); n.id = '0; n.we = 1'b0; n.d = '0;
    if (eg >= 0) begin
      n.id = NR'(1) << eg;
      n.we = req_we[eg];
      if (req_we[eg]) begin
        for (int b = 0; b < BEW; b++)
          if (req_be[eg][b]) ref_mem[req_addr[eg]][b*8 +: 8] = req_wdata[eg][b*8 +: 8];
      end else n.d = ref_mem[req_addr[eg]];
    end
    if (!rst_n) begin
      rr_m = 0;
      pipe_m.delete();
      for (int i = 0; i < LAT; i++) pipe_m.push_back('{v: 1'b0, id: '0, we: 1'b0, d: '0});
    end else begin
      void'(pipe_m.pop_front());
      pipe_m.push_back(n);
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
      if (eg > 0) rr_m = (eg + 1) % NR;
`else
      if (eg >= 0) rr_m = (eg + 1) % NR;
`endif
    end
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) begin eval_cycle(); advance(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b1;
    req_valid = '1; req_we = '0; req_be = '1;
    for (int r = 0; r < NR; r++) begin req_addr[r] = AW'(r); req_wdata[r] = '0; end
    eval_cycle(); advance();
    clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval_cycle();
      tests++;
      if (rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid cyc%0d got=%b exp=0", c, rsp_valid); end
      tests++;
      if (rsp_we !== 1'b0) begin fails++; $display("FAIL reset_rsp_we cyc%0d got=%b exp=0", c, rsp_we); end
      advance();
    end
    rst_n = 1'b1;
    eval_cycle();
    tests++;
    if (rsp_valid !== '0) begin fails++; $display("FAIL reset_release_rsp got=%b exp=0", rsp_valid); end
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", req_ready); end
    advance();
    idle(LAT + 1);
  endtask

  task automatic test_single();
    for (int c = 0; c <= LAT + 1; c++) begin
      req_valid = '0;
      if (c < 2) begin
        req_valid[1] = 1'b1; req_we[1] = (c == 0); req_addr[1] = AW'(5);
        req_wdata[1] = 32'hDEAD; req_be[1] = '1;
      end
      eval_cycle();
      if (c < 2) begin
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_grant c%0d got=%b exp=0010", c, req_ready); end
      end
      if (c == LAT) begin
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_we !== 1'b1) begin
          fails++; $display("FAIL single_wack got=%b/%b exp=0010/1", rsp_valid, rsp_we);
        end
      end
      if (c == LAT + 1) begin
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_we !== 1'b0 || rsp_rdata !== 32'hDEAD) begin
          fails++; $display("FAIL single_read got=%b/%b/%h exp=0010/0/0000dead", rsp_valid, rsp_we, rsp_rdata);
        end
      end
      advance();
    end
    idle(LAT + 1);
  endtask

  task automatic test_contention();
    int start = rr_m;
    logic [NR-1:0] exp;
    req_we = '0;
    for (int i = 0; i < 8; i++) begin
      req_valid = '1;
      eval_cycle();
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
      exp = 4'b0001;
`else
      exp = NR'(1) << ((start + i) % NR);
`endif
      tests++;
      if (req_ready !== exp) begin fails++; $display("FAIL contention_grant c%0d got=%b exp=%b", i, req_ready, exp); end
      tests++;
      if ($countones(req_ready) != 1) begin fails++; $display("FAIL contention_onehot c%0d got=%b exp=onehot", i, req_ready); end
      advance();
    end
    idle(LAT + 1);
  endtask

  task automatic test_back_to_back();
    bit [DW-1:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    for (int c = 0; c <= LAT + 3; c++) begin
      req_valid = '0; req_be = '1;
      case (c)
        0: begin req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = AW'(10); req_wdata[2] = d0; end
        1: begin req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = AW'(11); req_wdata[3] = d1; end
        2: begin req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = AW'(10); end
        3: begin req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = AW'(11); end
        default: ;
      endcase
      eval_cycle();
      if (c == LAT + 2) begin
        tests++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== d0) begin
          fails++; $display("FAIL b2b_rsp0 got=%b/%h exp=0001/%h", rsp_valid, rsp_rdata, d0);
        end
      end
      if (c == LAT + 3) begin
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== d1) begin
          fails++; $display("FAIL b2b_rsp1 got=%b/%h exp=0010/%h", rsp_valid, rsp_rdata, d1);
        end
      end
      advance();
    end
    idle(LAT + 1);
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c <= LAT + 1; c++) begin
      req_valid = '0;
      rst_n = (c != 1);
      if (c == 0) begin req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = AW'(3); end
      eval_cycle();
      if (c >= 2) begin
        tests++;
        if (rsp_valid !== '0) begin fails++; $display("FAIL midflight_rsp c%0d got=%b exp=0", c, rsp_valid); end
      end
      advance();
    end
    rst_n = 1'b1;
    idle(LAT + 1);
  endtask

`ifdef AXI_LLC_DATA_ARB_PRIO_EN
  task automatic test_prio();
    req_we = '0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0010;
      if (c < 4) req_valid[0] = 1'b1;
      eval_cycle();
      tests++;
      if (req_ready !== ((c < 4) ? 4'b0001 : 4'b0010)) begin
        fails++; $display("FAIL prio_grant c%0d got=%b", c, req_ready);
      end
      advance();
    end
    idle(LAT + 1);
  endtask
`endif

  task automatic test_random();
    logic [NR-1:0] exp_rdy;
    int last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++)
        if (!(req_valid[r] && last_g != r && c > 0)) begin
          req_valid[r] = ($urandom_range(0, 3) != 0);
          req_we[r]    = $urandom_range(0, 1);
          req_addr[r]  = AW'($urandom_range(0, 7));
          req_wdata[r] = $urandom;
          req_be[r]    = BEW'($urandom);
        end
      eval_cycle();
      exp_rdy = (eg >= 0) ? (NR'(1) << eg) : '0;
      tests++;
      if (req_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      tests++;
      if (eg >= 0) begin
        if (sram_req !== 1'b1 || sram_we !== req_we[eg] || sram_addr !== req_addr[eg] ||
            sram_wdata !== req_wdata[eg] || sram_be !== req_be[eg]) begin
          fails++; $display("FAIL rnd_sram c%0d got=%b/%b/%h/%h/%h exp g=%0d", c, sram_req, sram_we, sram_addr, sram_wdata, sram_be, eg);
        end
      end else if ({sram_req, sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
        fails++; $display("FAIL rnd_sram_idle c%0d got=%b/%b/%h/%h/%h exp=0", c, sram_req, sram_we, sram_addr, sram_wdata, sram_be);
      end
      tests++;
      if (rsp_valid !== (er.v ? er.id : '0) || rsp_we !== er.we) begin
        fails++; $display("FAIL rnd_rsp c%0d got=%b/%b exp=%b/%b", c, rsp_valid, rsp_we, er.v ? er.id : '0, er.we);
      end
      if (er.v && !er.we) begin
        tests++;
        if (rsp_rdata !== er.d) begin fails++; $display("FAIL rnd_rdata c%0d got=%h exp=%h", c, rsp_rdata, er.d); end
      end
      last_g = eg;
      advance();
    end
    idle(LAT + 1);
  endtask

  initial begin
    tests = 0; fails = 0; rr_m = 0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    for (int i = 0; i < LAT; i++) pipe_m.push_back('{v: 1'b0, id: '0, we: 1'b0, d: '0});
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_midflight();
`ifdef AXI_LLC_DATA_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_llc_data_sram_arb.md
# axi_llc_data_sram_arb

Round-robin arbiter and response sequencer that shares one data-SRAM port between `NumReq` LLC units (e.g. refill, eviction, read, write). It sits directly in front of the data-way SRAM macro wrapper. Each cycle it grants at most one valid request and drives the SRAM port. It tracks every granted access through a `Latency`-deep pipeline, so read data and write acknowledges return to the originating requester in the correct cycle.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, ≥1.
- `NumWords`, 1024: SRAM depth.
- `DataWidth`, 128: data width in bits.
- `ByteWidth`, 8: bits per byte-enable.
- `Latency`, 1: SRAM read latency in cycles, ≥1.
- `AddrWidth`, derived: `$clog2(NumWords)`, minimum 1.
- `BeWidth`, derived: ceil(`DataWidth`/`ByteWidth`).

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Synchronous, active-low; one clock only.
- `req_valid_i`, in, `NumReq`: per-requester request valid.
- `req_ready_o`, out, `NumReq`: per-requester grant; one-hot or zero.
- `req_we_i`, in, `NumReq`: 1 = write, 0 = read.
- `req_addr_i`, in, `NumReq` x `AddrWidth`: word address.
- `req_wdata_i`, in, `NumReq` x `DataWidth`: write data.
- `req_be_i`, in, `NumReq` x `BeWidth`: byte enables.
- `rsp_valid_o`, out, `NumReq`: response strobe to requester i.
- `rsp_we_o`, out, 1: the response is a write acknowledge.
- `rsp_rdata_o`, out, `DataWidth`: read data, broadcast to all requesters.
- `sram_req_o`, out, 1: SRAM request.
- `sram_we_o`, out, 1: SRAM write enable.
- `sram_addr_o`, out, `AddrWidth`: SRAM address.
- `sram_wdata_o`, out, `DataWidth`: SRAM write data.
- `sram_be_o`, out, `BeWidth`: SRAM byte enables.
- `sram_rdata_i`, in, `DataWidth`: SRAM read data.

## Operation
- Arbitration is combinational from `req_valid_i` and the round-robin pointer `rr_q`.
  - The grant goes to the first valid index ≥ `rr_q`, wrapping modulo `NumReq`.
  - `req_ready_o[g]` = 1 only for the granted index g.
  - With no valid request, `req_ready_o` = 0.
- Handshake: an access transfers when valid & ready.
  - A requester holds valid, we, addr, wdata and be stable until ready.
  - The arbiter never withdraws a grant combinationally while the request is held.
- Pointer update: on a transfer, `rr_q` ← (g+1) mod `NumReq`. Otherwise it holds.
- SRAM drive:
  - `sram_req_o` = any transfer.
  - `sram_we_o`, `sram_addr_o`, `sram_wdata_o`, `sram_be_o` are muxed from g.
  - With no transfer, they are driven to 0.
- Response pipeline: `Latency` registered stages, each holding {valid, one-hot id, we}.
  - Stage 0 loads the transfer.
  - Each stage shifts every cycle. There is no backpressure; requesters must accept responses.
- Response outputs from the last stage:
  - `rsp_valid_o` = valid & id.
  - `rsp_we_o` = we.
  - `rsp_rdata_o` = `sram_rdata_i` when the stage is a read, else 0.
- Throughput: one access per cycle, sustained. Reads and writes interleave freely.
- Same-address ordering: SRAM port order equals grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing
- Reset (`rst_ni` = 0 at a rising edge):
  - `rr_q` = 0 and all pipeline valids = 0.
  - Therefore `rsp_valid_o` = 0 and `rsp_we_o` = 0 from the next cycle.
  - `req_ready_o` and `sram_*` remain combinational and follow the inputs.
- Reset mid-operation: in-flight accesses are dropped. No response is issued for them after reset.
- Latency: a transfer in cycle T produces `rsp_valid_o` in cycle T+`Latency`. Write acknowledges use the same latency.
- Simultaneous requests: each requester in a set of N continuously valid requesters is granted once every N cycles. Worst-case wait is `NumReq`-1 cycles.
- `NumReq` = 1: the grant equals `req_valid_i[0]` and the pointer stays at 0.

## Configuration
- `AXI_LLC_DATA_ARB_PRIO_EN` defined: requester 0 has strict fixed priority over the others. The remaining requesters rotate round-robin among themselves whenever requester 0 is idle. `rr_q` updates only on grants to indices ≥1.
- Not defined: pure round-robin over all `NumReq` requesters, as described above.

## Test plan
- Reset: hold `rst_ni` low 3 cycles with all requests valid → `rsp_valid_o` = 0 throughout and through 1 cycle after release. First grant after release goes to index 0.
- Single requester: requester 1 writes 0xDEAD to addr 5, then reads addr 5, with `Latency` = 1.
  - Write grant at T gives `rsp_valid_o` = 2'b10 and `rsp_we_o` = 1 at T+1.
  - Read grant at T+1 gives `rsp_rdata_o` = 0xDEAD at T+2.
- Contention: `NumReq` = 4, all valid for 8 cycles → grants 0,1,2,3,0,1,2,3. Exactly one `req_ready_o` bit set each cycle.
- Latency 3: back-to-back reads by requesters 0 and 1 at T and T+1 → responses at T+3 (id 0) and T+4 (id 1), each carrying the correct data.
- Reset mid-flight: `Latency` = 2, grant a read at T, assert reset at T+1 → no `rsp_valid_o` at T+2.
- Priority build (`AXI_LLC_DATA_ARB_PRIO_EN`): requesters 0 and 1 both valid for 4 cycles → requester 0 is granted all 4 cycles. Requester 1 is granted at the first cycle requester 0 is idle.
